// File: rtl/result_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector_pkg
//  Description : Shared defaults, FSM state encoding and pointer-width helper
//                for the result collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package result_collector_pkg;

    localparam int unsigned c_data_w    = 8;
    localparam int unsigned c_frame_len = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // A depth of one still needs a one-bit pointer to stay legal
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_collector_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector_frame_buffer
//  Description : One-frame word store with write count, read pointer and a
//                registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_collector_frame_buffer
    import result_collector_pkg::*;
#(
    parameter int unsigned DATA_W    = c_data_w,
    parameter int unsigned FRAME_LEN = c_frame_len
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              last_wr,
    output logic              last_rd
);

    localparam int unsigned          c_ptr_w = ptr_w(FRAME_LEN);
    localparam logic [c_ptr_w-1:0]   c_last  = c_ptr_w'(FRAME_LEN - 1);
    localparam logic [c_ptr_w-1:0]   c_one   = c_ptr_w'(1);

    logic [DATA_W-1:0]  r_mem [FRAME_LEN];
    logic [c_ptr_w-1:0] r_wr_cnt;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [DATA_W-1:0]  r_rd_data;

    assign last_wr = (r_wr_cnt == c_last);
    assign last_rd = (r_rd_ptr == c_last);
    assign rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_cnt] <= wr_data;
        end
    end

    // Pointers park on the last slot; only the frame-complete clear wraps them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (clr) begin
                r_wr_cnt <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (wr_en && !last_wr) begin
                    r_wr_cnt <= r_wr_cnt + c_one;
                end
                if (rd_en && !last_rd) begin
                    r_rd_ptr <= r_rd_ptr + c_one;
                end
            end
            if (rd_en) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector
//  Description : Collects FRAME_LEN result words, then drains them in order;
//                tracks busy / frame-ready status and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_collector
    import result_collector_pkg::*;
#(
    parameter int unsigned DATA_W    = c_data_w,
    parameter int unsigned FRAME_LEN = c_frame_len
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_rdy,
    output logic              busy,
    output logic              overflow,
    input  logic              clr_ovf
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_wr_en;
    logic   w_rd_en;
    logic   w_clr;
    logic   w_ovf_evt;
    logic   w_last_wr;
    logic   w_last_rd;
    logic   r_rd_valid;
    logic   r_overflow;

    result_collector_frame_buffer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .clr     (w_clr),
        .rd_data (rd_data),
        .last_wr (w_last_wr),
        .last_rd (w_last_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reads are only honoured once the frame is complete; writes only before
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_clr       = 1'b0;
        w_ovf_evt   = 1'b0;
        case (r_state)
            IDLE, COLLECT: begin
                if (wr_req) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = w_last_wr ? DRAIN : COLLECT;
                end
            end
            DRAIN: begin
                w_ovf_evt = wr_req;
                if (rd_req) begin
                    w_rd_en = 1'b1;
                    if (w_last_rd) begin
                        w_clr       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Set has priority over clear so a coincident overflow is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign overflow  = r_overflow;
    assign frame_rdy = (r_state == DRAIN);
    assign busy      = (r_state == COLLECT);

endmodule
`default_nettype wire
